// File: rtl/delay_meas_pkg.sv
// ----------------------------------------------------------------------------
// delay_meas_pkg
//   Shared types and constants for the delay measurement block.
//   DELAY_W_DEF : default width of the measured delay
//   state_t     : measurement FSM states
//   max_cnt()   : largest delay representable in a given width
// ----------------------------------------------------------------------------
package delay_meas_pkg;

    localparam int unsigned DELAY_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT
    } state_t;

    function automatic int unsigned max_cnt(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/delay_meas_edge_det.sv
// ----------------------------------------------------------------------------
// edge_det
//   Edge detector of one signal: one history flop plus XOR.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   sig_i   : monitored signal
//   edge_o  : 1 when sig_i differs from its value in the previous cycle
//   level_o : current value of sig_i (polarity of a detected edge)
// ----------------------------------------------------------------------------
module edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_o,
    output logic level_o
);

    logic r_hist;

    // Reset loads the live input so the first cycle after reset never reports
    // a false edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hist <= sig_i;
        end else begin
            r_hist <= sig_i;
        end
    end

    assign edge_o  = sig_i ^ r_hist;
    assign level_o = sig_i;

endmodule

// File: rtl/delay_meas.sv
// ----------------------------------------------------------------------------
// delay_meas
//   Measures the latency, in clock cycles, between the first edge on a
//   reference signal and the next same-polarity edge on its delayed copy.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   start_i    : one-cycle request to arm a measurement (ignored while busy)
//   data_i     : reference signal (delay line input)
//   data_dly_i : delayed signal (delay line output)
//   busy_o     : measurement in progress
//   delay_o    : last measured delay, held until the next valid_o
//   valid_o    : one-cycle pulse, delay_o updated
//   timeout_o  : one-cycle pulse, no matching edge within max_cnt cycles
// ----------------------------------------------------------------------------
module delay_meas
    import delay_meas_pkg::*;
#(
    parameter int unsigned DELAY_W = DELAY_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               data_i,
    input  logic               data_dly_i,
    output logic               busy_o,
    output logic [DELAY_W-1:0] delay_o,
    output logic               valid_o,
    output logic               timeout_o
);

    localparam logic [DELAY_W-1:0] MAX_CNT = DELAY_W'(max_cnt(DELAY_W));

    logic w_ref_edge;
    logic w_ref_level;
    logic w_dly_edge;
    logic w_dly_level;

    state_t             r_state;
    logic [DELAY_W-1:0] r_cnt;
    logic               r_pol;
    logic               r_busy;
    logic [DELAY_W-1:0] r_delay;
    logic               r_valid;
    logic               r_timeout;

    // Identical detectors on both paths so a d-cycle line measures exactly d.
    edge_det u_ref_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sig_i   (data_i),
        .edge_o  (w_ref_edge),
        .level_o (w_ref_level)
    );

    edge_det u_dly_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sig_i   (data_dly_i),
        .edge_o  (w_dly_edge),
        .level_o (w_dly_level)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pol     <= 1'b0;
            r_busy    <= 1'b0;
            r_delay   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (w_ref_edge) begin
                        r_pol <= w_ref_level;
                        if (w_dly_edge && (w_dly_level == w_ref_level)) begin
                            r_delay <= '0;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= DELAY_W'(1);
                            r_state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    // A match on the last count wins over the timeout.
                    if (w_dly_edge && (w_dly_level == r_pol)) begin
                        r_delay <= r_cnt;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == MAX_CNT) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + DELAY_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign delay_o   = r_delay;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_delay_meas.sv
module tb_delay_meas;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       data_i = 1'b0;
    logic       data_dly_i;
    logic       busy_o;
    logic [3:0] delay_o;
    logic       valid_o;
    logic       timeout_o;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;

    // Behavioural delay line: data_dly_i(t) = data_i(t - tap).
    int         tap = 0;
    bit         disc = 1'b0;
    logic [15:0] line_q = '0;

    typedef struct {
        bit         is_to;
        logic [3:0] dly;
        int         at_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        line_q <= {line_q[14:0], data_i};
    end

    always_comb begin
        data_dly_i = 1'b0;
        if (!disc) begin
            if (tap == 0) data_dly_i = data_i;
            else          data_dly_i = line_q[tap-1];
        end
    end

    delay_meas #(.DELAY_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .data_i     (data_i),
        .data_dly_i (data_dly_i),
        .busy_o     (busy_o),
        .delay_o    (delay_o),
        .valid_o    (valid_o),
        .timeout_o  (timeout_o)
    );

    // Scoreboard side: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (valid_o || timeout_o) begin
            exp_t e;
            n_checks++;
            if (valid_o && timeout_o) begin
                n_errors++;
                $display("FAIL both_pulses: valid_o=1 timeout_o=1 at cycle %0d, need one", cyc);
            end
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: valid_o=%0b timeout_o=%0b at cycle %0d, none expected",
                         valid_o, timeout_o, cyc);
            end else begin
                e = sb.pop_front();
                if (timeout_o !== e.is_to || delay_o !== e.dly || cyc != e.at_cyc
                    || busy_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL result: got to=%0b delay=%0d cyc=%0d busy=%0b, need to=%0b delay=%0d cyc=%0d busy=0",
                             timeout_o, delay_o, cyc, busy_o, e.is_to, e.dly, e.at_cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) sb.delete();
    endtask

    // Settle the line at ~p, select the tap, arm, then drive a p-polarity edge.
    task automatic run_meas(input int t, input bit p, input bit to_exp, input logic [3:0] exp_dly);
        exp_t e;
        data_i = ~p;
        repeat (17) step();
        tap = t;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        data_i  = p;
        e.is_to  = to_exp;
        e.dly    = exp_dly;
        e.at_cyc = to_exp ? cyc + 16 : cyc + t + 1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_i  = 1'b1;
        data_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || delay_o !== 4'd0 || valid_o !== 1'b0 || timeout_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: busy=%0b delay=%0d valid=%0b timeout=%0b, need all 0",
                     busy_o, delay_o, valid_o, timeout_o);
        end
        repeat (5) step();
        n_checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: busy=%0b valid=%0b, need 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_tap5_rise();
        bit ok;
        run_meas(5, 1'b1, 1'b0, 4'd5);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL tap5_done: got no result, need delay 5");
        end
    endtask

    task automatic test_tap0_fall();
        bit ok;
        run_meas(0, 1'b0, 1'b0, 4'd0);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL tap0_done: got no result, need delay 0");
        end
    endtask

    task automatic test_tap15_timeout();
        bit ok;
        run_meas(15, 1'b1, 1'b0, 4'd15);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL tap15_done: got no result, need delay 15");
        end
        disc = 1'b1;
        run_meas(15, 1'b0, 1'b1, 4'd15);
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL timeout_done: got no pulse, need timeout");
        end
        n_checks++;
        if (delay_o !== 4'd15) begin
            n_errors++;
            $display("FAIL timeout_hold: delay_o=%0d, need 15", delay_o);
        end
        disc = 1'b0;
    endtask

    task automatic test_first_edge();
        bit ok;
        exp_t e;
        data_i = 1'b0;
        repeat (17) step();
        tap = 8;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        data_i  = 1'b1;
        e.is_to = 1'b0; e.dly = 4'd8; e.at_cyc = cyc + 9;
        sb.push_back(e);
        step();
        start_i = 1'b1;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_set: busy_o=%0b, need 1", busy_o);
        end
        step();
        start_i = 1'b0;
        step();
        data_i = 1'b0;
        step();
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL first_edge_done: got no result, need delay 8");
        end
        step();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL no_restart: busy_o=%0b after result, need 0", busy_o);
        end
        repeat (20) step();
    endtask

    task automatic test_mid_reset();
        data_i = 1'b0;
        repeat (17) step();
        tap = 10;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        data_i  = 1'b1;
        repeat (4) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || delay_o !== 4'd0 || valid_o !== 1'b0 || timeout_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: busy=%0b delay=%0d valid=%0b timeout=%0b, need all 0",
                     busy_o, delay_o, valid_o, timeout_o);
        end
        // Any pulse from here on hits an empty scoreboard and is flagged.
        repeat (25) step();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_idle: busy_o=%0b, need 0", busy_o);
        end
    endtask

    task automatic test_random();
        bit ok;
        int t;
        bit p;
        int n_bad = 0;
        for (int k = 0; k < 100; k++) begin
            t = $urandom_range(0, 15);
            p = 1'($urandom_range(0, 1));
            run_meas(t, p, 1'b0, 4'(t));
            wait_done(ok);
            if (!ok) n_bad++;
        end
        n_checks++;
        if (n_bad != 0) begin
            n_errors++;
            $display("FAIL random_done: %0d measurements without result, need 0", n_bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, need finish");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_tap5_rise();
        test_tap0_fall();
        test_tap15_timeout();
        test_first_edge();
        test_mid_reset();
        test_random();
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
